// File: rtl/nmt_rank_switch_ctrl_pkg.sv
// Shared types and constants for the NMT/host rank switch controller and its predictor.
package nmt_pkg;

    localparam logic [1:0] ST_NMT_OWN    = 2'd0;
    localparam logic [1:0] ST_DRAIN      = 2'd1;
    localparam logic [1:0] ST_HOST_OWN   = 2'd2;
    localparam logic [1:0] ST_TURNAROUND = 2'd3;

    typedef enum logic [1:0] {
        NMT_OWN    = ST_NMT_OWN,
        DRAIN      = ST_DRAIN,
        HOST_OWN   = ST_HOST_OWN,
        TURNAROUND = ST_TURNAROUND
    } state_e;

    typedef enum logic {
        OWNER_NMT  = 1'b0,
        OWNER_HOST = 1'b1
    } owner_e;

    localparam logic       READ      = 1'b0;
    localparam logic       WRITE     = 1'b1;
    localparam logic [1:0] NMT_WRITE = 2'b00;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/nmt_rank_switch_ctrl_if.sv
// Request/grant bundle between the rank switch controller and its environment.
interface nmt_rank_switch_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             context_switch;
    logic [3:0]       nmt_inflight;
    logic             host_req_valid;
    logic             nmt_ready;
    logic             host_grant;
    logic             rank_owner;
    logic             drain_timeout;
    logic [CNT_W-1:0] switch_count;

    modport master (
        output context_switch, nmt_inflight, host_req_valid,
        input  nmt_ready, host_grant, rank_owner, drain_timeout, switch_count
    );

    modport slave (
        input  context_switch, nmt_inflight, host_req_valid,
        output nmt_ready, host_grant, rank_owner, drain_timeout, switch_count
    );
endinterface

// File: rtl/nmt_rank_switch_ctrl_timer.sv
// Loadable down-counter; holds at zero, load wins over decrement.
module cycle_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/nmt_rank_switch_ctrl.sv
// Hands one DRAM rank from the NMT engine to the host and back: stall, drain, host window, turnaround.
//  state      | meaning
//  NMT_OWN    | NMT engine owns the rank and may issue
//  DRAIN      | new NMT ops stalled, waiting for in-flight ops or timeout
//  HOST_OWN   | host owns the rank (base window, then optional extension)
//  TURNAROUND | bus idle gap before NMT resumes
module nmt_rank_switch_ctrl
    import nmt_pkg::*;
#(
    parameter int DRAIN_MAX   = 16,
    parameter int HOST_WINDOW = 8,
    parameter int TURN_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    nmt_rank_switch_ctrl_if.slave  bus
);
    localparam int TW = $clog2(max3(DRAIN_MAX, HOST_WINDOW, TURN_CYCLES)) + 1;

    logic [1:0]       state, state_nxt;
    logic             cs_q, switch_req;
    logic             ext, ext_nxt;
    logic             t_load, t_dec, t_zero;
    logic [TW-1:0]    t_val;
    logic             to_nxt, cnt_inc;
    logic             nmt_ready_q, host_grant_q, rank_owner_q, drain_timeout_q;
    logic [CNT_W-1:0] count_q;

    assign switch_req = bus.context_switch & ~cs_q;

    cycle_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .dec      (t_dec),
        .zero     (t_zero)
    );

    always_comb begin
        state_nxt = state;
        ext_nxt   = ext;
        t_load    = 1'b0;
        t_val     = '0;
        t_dec     = 1'b0;
        to_nxt    = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            ST_NMT_OWN: begin
                if (switch_req) begin
                    state_nxt = ST_DRAIN;
                    t_load    = 1'b1;
                    t_val     = TW'(DRAIN_MAX - 1);
                end
            end
            ST_DRAIN: begin
                if ((bus.nmt_inflight == 4'd0) || t_zero) begin
                    state_nxt = ST_HOST_OWN;
                    to_nxt    = (bus.nmt_inflight != 4'd0);
                    cnt_inc   = 1'b1;
                    ext_nxt   = 1'b0;
                    t_load    = 1'b1;
                    t_val     = TW'(HOST_WINDOW - 1);
                end else begin
                    t_dec = 1'b1;
                end
            end
            ST_HOST_OWN: begin
                // Extension ends early on host idle; base window always runs to completion.
                if (ext && !bus.host_req_valid) begin
                    state_nxt = ST_TURNAROUND;
                    ext_nxt   = 1'b0;
                    t_load    = 1'b1;
                    t_val     = TW'(TURN_CYCLES - 1);
                end else if (!t_zero) begin
                    t_dec = 1'b1;
                end else if (!ext && bus.host_req_valid) begin
                    ext_nxt = 1'b1;
                    t_load  = 1'b1;
                    t_val   = TW'(HOST_WINDOW - 1);
                end else begin
                    state_nxt = ST_TURNAROUND;
                    ext_nxt   = 1'b0;
                    t_load    = 1'b1;
                    t_val     = TW'(TURN_CYCLES - 1);
                end
            end
            ST_TURNAROUND: begin
                if (t_zero) state_nxt = ST_NMT_OWN;
                else        t_dec     = 1'b1;
            end
            default: state_nxt = ST_NMT_OWN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_NMT_OWN;
            cs_q            <= 1'b0;
            ext             <= 1'b0;
            nmt_ready_q     <= 1'b1;
            host_grant_q    <= 1'b0;
            rank_owner_q    <= OWNER_NMT;
            drain_timeout_q <= 1'b0;
            count_q         <= '0;
        end else begin
            state           <= state_nxt;
            cs_q            <= bus.context_switch;
            ext             <= ext_nxt;
            nmt_ready_q     <= (state_nxt == ST_NMT_OWN);
            host_grant_q    <= (state_nxt == ST_HOST_OWN);
            rank_owner_q    <= ((state_nxt == ST_HOST_OWN) || (state_nxt == ST_TURNAROUND))
                               ? OWNER_HOST : OWNER_NMT;
            drain_timeout_q <= to_nxt;
            if (cnt_inc && (count_q != '1)) count_q <= count_q + 1'b1;
        end
    end

    assign bus.nmt_ready     = nmt_ready_q;
    assign bus.host_grant    = host_grant_q;
    assign bus.rank_owner    = rank_owner_q;
    assign bus.drain_timeout = drain_timeout_q;
    assign bus.switch_count  = count_q;
endmodule

// File: tb/tb_nmt_rank_switch_ctrl.sv
// Directed bench for nmt_rank_switch_ctrl; out vector is {nmt_ready, host_grant, rank_owner, drain_timeout}.
module tb_nmt_rank_switch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    nmt_rank_switch_ctrl_if #(.CNT_W(16)) bus ();

    nmt_rank_switch_ctrl #(
        .DRAIN_MAX(16), .HOST_WINDOW(8), .TURN_CYCLES(2), .CNT_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] O_NMT   = 4'b1000;
    localparam logic [3:0] O_DRAIN = 4'b0000;
    localparam logic [3:0] O_HOST  = 4'b0110;
    localparam logic [3:0] O_HTO   = 4'b0111;
    localparam logic [3:0] O_TURN  = 4'b0010;

    logic [3:0] o;
    assign o = {bus.nmt_ready, bus.host_grant, bus.rank_owner, bus.drain_timeout};

    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            assert (!(bus.host_grant === 1'b1 && bus.nmt_ready === 1'b1)) else begin
                fails++;
                $error("FAIL mutex observed grant=%b ready=%b expected not both 1",
                       bus.host_grant, bus.nmt_ready);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_for(input string tag, input logic [3:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, {28'd0, o}, {28'd0, exp});
            step(1);
        end
    endtask

    task automatic pulse_cs;
        bus.context_switch = 1'b1;
        step(1);
        bus.context_switch = 1'b0;
    endtask

    initial begin
        bus.context_switch = 1'b0;
        bus.nmt_inflight   = 4'd0;
        bus.host_req_valid = 1'b0;

        // reset and idle
        rst = 1'b1;
        step(3);
        chk("reset_out", {28'd0, o}, {28'd0, O_NMT});
        chk("reset_cnt", {16'd0, bus.switch_count}, 32'd0);
        rst = 1'b0;
        step(1);
        check_for("idle", O_NMT, 10);
        chk("idle_cnt", {16'd0, bus.switch_count}, 32'd0);

        // clean handover
        pulse_cs();
        check_for("clean_drain", O_DRAIN, 1);
        chk("clean_cnt", {16'd0, bus.switch_count}, 32'd1);
        check_for("clean_host", O_HOST, 8);
        check_for("clean_turn", O_TURN, 2);
        check_for("clean_nmt", O_NMT, 3);

        // drain timeout
        bus.nmt_inflight = 4'd3;
        pulse_cs();
        check_for("to_drain", O_DRAIN, 16);
        check_for("to_first_host", O_HTO, 1);
        check_for("to_host", O_HOST, 7);
        bus.nmt_inflight = 4'd0;
        check_for("to_turn", O_TURN, 2);
        check_for("to_nmt", O_NMT, 2);
        chk("to_cnt", {16'd0, bus.switch_count}, 32'd2);

        // host extension, request held throughout
        bus.host_req_valid = 1'b1;
        pulse_cs();
        check_for("ext_drain", O_DRAIN, 1);
        check_for("ext_host", O_HOST, 16);
        check_for("ext_turn", O_TURN, 2);
        bus.host_req_valid = 1'b0;
        check_for("ext_nmt", O_NMT, 2);
        chk("ext_cnt", {16'd0, bus.switch_count}, 32'd3);

        // host extension, request dropped in grant cycle 10
        bus.host_req_valid = 1'b1;
        pulse_cs();
        check_for("drop_drain", O_DRAIN, 1);
        check_for("drop_host", O_HOST, 9);
        bus.host_req_valid = 1'b0;
        check_for("drop_host10", O_HOST, 1);
        check_for("drop_turn", O_TURN, 2);
        check_for("drop_nmt", O_NMT, 2);
        chk("drop_cnt", {16'd0, bus.switch_count}, 32'd4);

        // level hold plus re-pulse during host ownership
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        bus.context_switch = 1'b1;
        step(1);
        check_for("hold_drain", O_DRAIN, 1);
        check_for("hold_host_a", O_HOST, 3);
        bus.context_switch = 1'b0;
        check_for("hold_host_b", O_HOST, 1);
        bus.context_switch = 1'b1;
        check_for("hold_host_c", O_HOST, 4);
        check_for("hold_turn", O_TURN, 2);
        check_for("hold_nmt", O_NMT, 18);
        bus.context_switch = 1'b0;
        check_for("hold_nmt_end", O_NMT, 2);
        chk("hold_cnt", {16'd0, bus.switch_count}, 32'd1);

        // reset while host owns the rank
        pulse_cs();
        check_for("mid_drain", O_DRAIN, 1);
        check_for("mid_host", O_HOST, 3);
        rst = 1'b1;
        step(1);
        chk("mid_rst_out", {28'd0, o}, {28'd0, O_NMT});
        chk("mid_rst_cnt", {16'd0, bus.switch_count}, 32'd0);
        rst = 1'b0;
        step(1);
        check_for("mid_idle", O_NMT, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
